// File: rtl/vga_line_fetcher.sv
// Fetches one video line into a downstream FIFO, either from memory in bursts
// or from a built-in test pattern generator (ramps / checkerboard).
module vga_line_fetcher #(
  parameter int H_ACTIVE   = 1024,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 24,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 512,
  parameter int LINE_W     = 13
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iLOAD_REQ,
  input  logic [LINE_W-1:0]             iLOAD_VLINE,
  input  logic [1:0]                    iMODE,
  input  logic [DATA_W-1:0]             iTEST_LEVEL,
  input  logic [ADDR_W-1:0]             iBASE_ADDR,
  output logic                          oRD_REQ,
  output logic [ADDR_W-1:0]             oRD_ADDR,
  input  logic                          iRD_GNT,
  input  logic                          iRD_VALID,
  input  logic [DATA_W-1:0]             iRD_DATA,
  output logic [DATA_W-1:0]             oWDATA,
  output logic                          oWEN,
  input  logic [$clog2(FIFO_DEPTH):0]   iWUSEDW,
  output logic                          oBUSY,
  output logic                          oDONE,
  output logic                          oOVERRUN
);

  localparam int PIX_W  = $clog2(H_ACTIVE + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int FW     = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_PAT, S_DONE} state_t;

  state_t              r_state;
  logic [LINE_W-1:0]   r_line;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_level;
  logic [PIX_W-1:0]    r_pix;
  logic [BEAT_W-1:0]   r_beat;
  logic [FW-1:0]       r_inflight;
  logic                r_rd_req;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wen;
  logic                r_busy;
  logic                r_done;
  logic                r_overrun;

  logic                w_space_ok;
  logic                w_pat_ok;
  logic                w_last_pix;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_pat;
  logic [FW-1:0]       w_inc;
  logic [FW-1:0]       w_dec;

  // In-flight pixels are granted beats not yet written; usedw lags our writes.
  assign w_space_ok = (32'(iWUSEDW) + 32'(r_inflight) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);
  assign w_pat_ok   = 32'(iWUSEDW) < 32'(FIFO_DEPTH - 1);
  assign w_last_pix = (r_pix == PIX_W'(H_ACTIVE - 1));
  assign w_addr     = iBASE_ADDR + ADDR_W'(r_line) * ADDR_W'(H_ACTIVE) + ADDR_W'(r_pix);
  assign w_inc      = (r_state == S_REQ && r_rd_req && iRD_GNT) ? FW'(BURST_LEN) : '0;
  assign w_dec      = (r_wen && r_mode == 2'd0) ? FW'(1) : '0;

  always_comb begin
    w_pat = '0;
    case (r_mode)
      2'd1:    w_pat = DATA_W'(r_pix) + r_level;
      2'd2:    w_pat = DATA_W'(r_line) + r_level;
      2'd3:    w_pat = (r_pix[3] ^ r_line[3]) ? r_level : '0;
      default: w_pat = '0;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= S_IDLE;
      r_line     <= '0;
      r_mode     <= '0;
      r_level    <= '0;
      r_pix      <= '0;
      r_beat     <= '0;
      r_inflight <= '0;
      r_rd_req   <= 1'b0;
      r_rd_addr  <= '0;
      r_wdata    <= '0;
      r_wen      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_wen      <= 1'b0;
      r_done     <= 1'b0;
      r_inflight <= r_inflight + w_inc - w_dec;
      if (iLOAD_REQ && r_state != S_IDLE) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (iLOAD_REQ) begin
            r_line  <= iLOAD_VLINE;
            r_mode  <= iMODE;
            r_level <= iTEST_LEVEL;
            r_pix   <= '0;
            r_beat  <= '0;
            r_busy  <= 1'b1;
            r_state <= (iMODE == 2'd0) ? S_REQ : S_PAT;
          end
        end
        S_REQ: begin
          // Once raised, request and address stay frozen until granted.
          if (!r_rd_req) begin
            if (w_space_ok) begin
              r_rd_req  <= 1'b1;
              r_rd_addr <= w_addr;
            end
          end else if (iRD_GNT) begin
            r_rd_req <= 1'b0;
            r_beat   <= '0;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (iRD_VALID) begin
            r_wen   <= 1'b1;
            r_wdata <= iRD_DATA;
            r_pix   <= r_pix + PIX_W'(1);
            r_beat  <= r_beat + BEAT_W'(1);
            if (w_last_pix) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
              r_state <= S_REQ;
            end
          end
        end
        S_PAT: begin
          if (w_pat_ok) begin
            r_wen   <= 1'b1;
            r_wdata <= w_pat;
            r_pix   <= r_pix + PIX_W'(1);
            if (w_last_pix) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oRD_REQ  = r_rd_req;
  assign oRD_ADDR = r_rd_addr;
  assign oWDATA   = r_wdata;
  assign oWEN     = r_wen;
  assign oBUSY    = r_busy;
  assign oDONE    = r_done;
  assign oOVERRUN = r_overrun;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Directed self-checking bench for vga_line_fetcher (H_ACTIVE=16, BURST_LEN=8).
module tb_vga_line_fetcher;
  localparam int H  = 16;
  localparam int DW = 8;
  localparam int AW = 24;
  localparam int BL = 8;
  localparam int FD = 512;
  localparam int LW = 13;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iLOAD_REQ = 1'b0;
  logic [LW-1:0] iLOAD_VLINE = '0;
  logic [1:0]    iMODE = '0;
  logic [DW-1:0] iTEST_LEVEL = '0;
  logic [AW-1:0] iBASE_ADDR = '0;
  logic          oRD_REQ;
  logic [AW-1:0] oRD_ADDR;
  logic          iRD_GNT = 1'b0;
  logic          iRD_VALID = 1'b0;
  logic [DW-1:0] iRD_DATA = '0;
  logic [DW-1:0] oWDATA;
  logic          oWEN;
  logic [9:0]    iWUSEDW = '0;
  logic          oBUSY;
  logic          oDONE;
  logic          oOVERRUN;

  int n_chk = 0;
  int n_err = 0;
  int wen_cnt = 0;
  int done_cnt = 0;
  int w0, d0c;

  vga_line_fetcher #(.H_ACTIVE(H), .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL),
                     .FIFO_DEPTH(FD), .LINE_W(LW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iLOAD_REQ(iLOAD_REQ), .iLOAD_VLINE(iLOAD_VLINE),
    .iMODE(iMODE), .iTEST_LEVEL(iTEST_LEVEL), .iBASE_ADDR(iBASE_ADDR),
    .oRD_REQ(oRD_REQ), .oRD_ADDR(oRD_ADDR), .iRD_GNT(iRD_GNT),
    .iRD_VALID(iRD_VALID), .iRD_DATA(iRD_DATA), .oWDATA(oWDATA), .oWEN(oWEN),
    .iWUSEDW(iWUSEDW), .oBUSY(oBUSY), .oDONE(oDONE), .oOVERRUN(oOVERRUN)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (oWEN)  wen_cnt++;
    if (oDONE) done_cnt++;
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    tick();
    tick();
    iRST = 1'b0;
  endtask

  task automatic load(input logic [1:0] mode, input logic [LW-1:0] line, input logic [DW-1:0] lvl);
    iMODE = mode;
    iLOAD_VLINE = line;
    iTEST_LEVEL = lvl;
    iLOAD_REQ = 1'b1;
    tick();
    iLOAD_REQ = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      if (oRD_REQ) break;
      tick();
    end
    check("rd_req_seen", 32'(oRD_REQ), 1);
  endtask

  task automatic do_burst(input logic [AW-1:0] a, input logic [DW-1:0] d0, input logic last);
    logic [DW-1:0] d;
    wait_req();
    check("rd_addr", 32'(oRD_ADDR), 32'(a));
    iRD_GNT = 1'b1;
    tick();
    iRD_GNT = 1'b0;
    check("rd_req_drop", 32'(oRD_REQ), 0);
    for (int i = 0; i < BL; i++) begin
      d = d0 + 8'(i);
      iRD_VALID = 1'b1;
      iRD_DATA = d;
      tick();
      check("mem_wen", 32'(oWEN), 1);
      check("mem_wdata", 32'(oWDATA), 32'(d));
    end
    iRD_VALID = 1'b0;
    check("mem_done", 32'(oDONE), 32'(last));
  endtask

  function automatic logic [DW-1:0] pat_exp(input logic [1:0] mode, input int x,
                                            input logic [LW-1:0] y, input logic [DW-1:0] lvl);
    logic [31:0] xv;
    xv = 32'(x);
    case (mode)
      2'd1:    return xv[7:0] + lvl;
      2'd2:    return y[7:0] + lvl;
      default: return (xv[3] ^ y[3]) ? lvl : 8'h00;
    endcase
  endfunction

  // ovr_at: write index during which a second load pulse is sent (16 = in DONE)
  task automatic run_pat(input logic [1:0] mode, input logic [LW-1:0] line,
                         input logic [DW-1:0] lvl, input int ovr_at, input int stall);
    int wb;
    wb = wen_cnt;
    load(mode, line, lvl);
    if (stall > 0) begin
      iWUSEDW = 10'(FD - 1);
      for (int i = 0; i < stall; i++) begin
        tick();
        check("pat_stall", 32'(oWEN), 0);
      end
      iWUSEDW = '0;
    end
    for (int i = 0; i < H; i++) begin
      iLOAD_REQ = (i == ovr_at);
      tick();
      check("pat_wen", 32'(oWEN), 1);
      check("pat_wdata", 32'(oWDATA), 32'(pat_exp(mode, i, line, lvl)));
    end
    iLOAD_REQ = 1'b0;
    check("pat_done", 32'(oDONE), 1);
    if (ovr_at == H) iLOAD_REQ = 1'b1;
    tick();
    iLOAD_REQ = 1'b0;
    check("pat_idle", 32'(oBUSY), 0);
    tick();
    check("pat_count", 32'(wen_cnt - wb), 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    do_reset();
    check("rst_busy", 32'(oBUSY), 0);
    check("rst_rd_req", 32'(oRD_REQ), 0);
    check("rst_wen", 32'(oWEN), 0);
    check("rst_done", 32'(oDONE), 0);
    check("rst_overrun", 32'(oOVERRUN), 0);
    check("rst_wdata", 32'(oWDATA), 0);
    check("rst_rd_addr", 32'(oRD_ADDR), 0);

    // memory line 2, base 0x100
    iBASE_ADDR = 24'h000100;
    w0 = wen_cnt;
    d0c = done_cnt;
    load(2'd0, 13'd2, 8'h00);
    check("busy_after_load", 32'(oBUSY), 1);
    do_burst(24'h000120, 8'h10, 1'b0);
    do_burst(24'h000128, 8'h18, 1'b1);
    tick();
    check("mem_idle", 32'(oBUSY), 0);
    check("mem_count", 32'(wen_cnt - w0), 16);
    check("mem_done_count", 32'(done_cnt - d0c), 1);

    // patterns: wrapping ramp, checker, vertical ramp with FIFO-full stall
    run_pat(2'd1, 13'd0, 8'hF8, -1, 0);
    run_pat(2'd3, 13'd8, 8'hAA, -1, 0);
    run_pat(2'd2, 13'h123, 8'h10, -1, 3);

    // FIFO almost full holds off the read request
    do_reset();
    iBASE_ADDR = '0;
    iWUSEDW = 10'd508;
    load(2'd0, 13'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("req_low_508", 32'(oRD_REQ), 0);
    end
    iWUSEDW = 10'd505;
    tick();
    tick();
    check("req_low_505", 32'(oRD_REQ), 0);
    iWUSEDW = 10'd504;
    tick();
    check("req_at_504", 32'(oRD_REQ), 1);
    iWUSEDW = 10'd508;
    tick();
    tick();
    check("req_stable", 32'(oRD_REQ), 1);
    check("addr_stable", 32'(oRD_ADDR), 0);
    iWUSEDW = 10'd504;
    do_burst(24'h000000, 8'h40, 1'b0);
    do_burst(24'h000008, 8'h48, 1'b1);
    tick();
    iWUSEDW = '0;

    // load during DONE is ignored but flags overrun
    do_reset();
    check("ovr_clear_a", 32'(oOVERRUN), 0);
    run_pat(2'd1, 13'd0, 8'h00, H, 0);
    check("ovr_done_cycle", 32'(oOVERRUN), 1);

    // load mid-line is ignored but flags overrun
    do_reset();
    check("ovr_clear_b", 32'(oOVERRUN), 0);
    w0 = wen_cnt;
    run_pat(2'd1, 13'd0, 8'h00, 3, 0);
    check("ovr_busy", 32'(oOVERRUN), 1);
    tick();
    tick();
    check("ovr_total", 32'(wen_cnt - w0), 16);
    check("ovr_idle", 32'(oBUSY), 0);

    // reset after three beats abandons the line
    do_reset();
    load(2'd0, 13'd1, 8'h00);
    wait_req();
    check("rst_mid_addr", 32'(oRD_ADDR), 32'h10);
    iRD_GNT = 1'b1;
    tick();
    iRD_GNT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iRD_VALID = 1'b1;
      iRD_DATA = 8'h50 + 8'(i);
      tick();
      check("rst_mid_wen", 32'(oWEN), 1);
    end
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    check("rst_mid_busy", 32'(oBUSY), 0);
    check("rst_mid_wen0", 32'(oWEN), 0);
    check("rst_mid_wdata", 32'(oWDATA), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray_beat", 32'(oWEN), 0);
    end
    iRD_VALID = 1'b0;
    w0 = wen_cnt;
    load(2'd0, 13'd1, 8'h00);
    do_burst(24'h000010, 8'h60, 1'b0);
    do_burst(24'h000018, 8'h68, 1'b1);
    tick();
    tick();
    check("refetch_count", 32'(wen_cnt - w0), 16);

    // address wrap, plus an excess beat between bursts
    do_reset();
    iBASE_ADDR = 24'hFFFFF8;
    w0 = wen_cnt;
    load(2'd0, 13'd0, 8'h00);
    do_burst(24'hFFFFF8, 8'h80, 1'b0);
    iRD_VALID = 1'b1;
    iRD_DATA = 8'hEE;
    tick();
    iRD_VALID = 1'b0;
    check("extra_beat", 32'(oWEN), 0);
    do_burst(24'h000000, 8'h88, 1'b1);
    tick();
    tick();
    check("wrap_count", 32'(wen_cnt - w0), 16);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
